lsu: RTL and testbench
======================

# lsu

Load/store unit for the execute-to-memory boundary of the RISC-V core. It consumes the ALU result as the effective address, together with the load/store opcode, `funct3` and `rs2` data. It issues a single-beat request to data memory with byte enables and lane-replicated store data. For loads, it returns the extracted, sign- or zero-extended value to writeback. The core stalls on `ex_ready` while a transaction is outstanding.

## Interface
Parameters:
- `REG_WIDTH`, 32, register/data width; only 32 is supported.
- `ADDR_WIDTH`, 32, data memory address width.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `ex_valid`  in  1  execute stage presents an operation.
- `ex_ready`  out  1  LSU can accept; high only in IDLE.
- `mem_read`  in  1  operation is a load.
- `mem_write`  in  1  operation is a store; takes precedence if both are set.
- `funct3`  in  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `addr`  in  REG_WIDTH  effective address (ALU result).
- `store_data`  in  REG_WIDTH  rs2 value.
- `rd_in`  in  5  load destination register.
- `dmem_req`  out  1  memory request, held until ack.
- `dmem_we`  out  1  1 = write.
- `dmem_addr`  out  ADDR_WIDTH  word-aligned address (bits [1:0] = 0).
- `dmem_be`  out  4  byte enables.
- `dmem_wdata`  out  32  lane-replicated store data.
- `dmem_ack`  in  1  request completed; `dmem_rdata` valid this cycle.
- `dmem_rdata`  in  32  read word.
- `wb_valid`  out  1  one-cycle pulse when load data is valid.
- `wb_rd`  out  5  destination of the returned load.
- `wb_data`  out  32  extended load result.
- `misalign`  out  1  misalignment trap pulse; tied 0 unless `LSU_MISALIGN_TRAP_EN` is defined.

## Operation
- **States:** IDLE, REQ, TRAP.
- **IDLE → REQ:** on `ex_valid & (mem_read|mem_write)`, the LSU latches the operation and computes the memory outputs.
  - `ex_valid` with neither `mem_read` nor `mem_write` set is ignored.
- **REQ:** `dmem_req=1`. `dmem_we`, `dmem_addr`, `dmem_be` and `dmem_wdata` are registered and stay stable.
- **REQ → IDLE:** on `dmem_ack`. For a load, `wb_data`/`wb_rd` are registered and `wb_valid` pulses for one cycle. A store produces no `wb_valid`.
- **Byte enables and store data:**
  - Byte: `be = 0001 << addr[1:0]`, `wdata = {4{sd[7:0]}}`.
  - Half: `be = 0011 << {addr[1],1'b0}`, `wdata = {2{sd[15:0]}}`.
  - Word: `be = 1111`, `wdata = sd`.
- **Load extraction:**
  - Byte lane selected by `addr[1:0]`; half lane selected by `addr[1]`.
  - B/H sign-extend; BU/HU zero-extend.
- **Reserved `funct3`:** 011, 110 and 111 are treated as word accesses.
- **Misalignment:** a half with `addr[0]=1` or a word with `addr[1:0]≠0`. Handling depends on `LSU_MISALIGN_TRAP_EN`; see Configuration.
- **Unexpected ack:** `dmem_ack` outside REQ is ignored.
- **Held outputs:** `wb_data`/`wb_rd` hold their last load value between pulses.

## Timing
- **Reset values:** state IDLE; `ex_ready=1`; all other outputs 0. Reset applies immediately on `reset_n` low, without waiting for a clock.
- **Reset mid-REQ:** `dmem_req` drops asynchronously. An ack arriving after reset is released is ignored.
- **Latency:** acceptance at edge 0 → `dmem_req` high in cycle 1.
  - Ack sampled at edge k≥1 → `wb_valid` high in cycle k+1.
  - Minimum load-to-writeback latency is 2 cycles.
- **Throughput:** at most one outstanding transaction. The next operation is accepted at the edge where the state is IDLE again, so with a zero-wait memory back-to-back ops are accepted every 2 cycles.
- **Ack in first REQ cycle:** an ack in the first REQ cycle is legal and completes the transaction.

## Configuration
- **`LSU_MISALIGN_TRAP_EN` defined:** a misaligned access goes IDLE→TRAP instead of REQ.
  - In TRAP: `misalign=1` for exactly one cycle, `ex_ready=0`, no `dmem_req`, no `wb_valid`.
  - Then the LSU returns to IDLE.
- **Not defined:** no TRAP state. Misaligned low address bits are ignored: a half uses `addr[1]` only, a word ignores `addr[1:0]`. `misalign` is constant 0.

## Test plan
- **LW, 3-cycle ack:** LW at `addr=0x100`, ack after 3 REQ cycles with `rdata=0xDEADBEEF` → `dmem_addr=0x100`, `be=1111`, `we=0`; `wb_valid` for one cycle with `wb_data=0xDEADBEEF`, `wb_rd=rd_in`.
- **LB/LBU sign extension:** `addr=0x103`, `rdata=0x80123456`. LB → `wb_data=0xFFFFFF80`; LBU → `0x00000080`.
- **SH lane placement:** `addr=0x202`, `store_data=0x1234ABCD` → `be=1100`, `wdata=0xABCDABCD`, `we=1`, no `wb_valid`.
- **Misaligned LW:** `addr=0x101`.
  - Without macro → `dmem_addr=0x100`, `be=1111`.
  - With macro → `misalign` pulses once, `dmem_req` stays 0, `ex_ready` returns to 1 after one cycle.
- **Reset during REQ:** assert `reset_n=0` while in REQ → `dmem_req=0` before the next clock edge, `ex_ready=1`. A subsequent `dmem_ack` produces no `wb_valid`.
- **Back-to-back with zero-wait ack:** SW then LW with `ex_valid` held high and ack in the first REQ cycle → the second op is accepted exactly 2 cycles after the first, and `ex_ready` is low in each REQ cycle.

Source files
------------

// File: rtl/lsu_if.sv
// lsu_if: execute-side, data-memory and writeback signal bundle of the load/store unit.
// Latency: none; pure wiring.
// Backpressure: ex_ready throttles the execute stage, dmem_ack completes the memory request.
interface lsu_if #(
    parameter int REG_WIDTH  = 32,
    parameter int ADDR_WIDTH = 32
);
    // execute stage side
    logic                   ex_valid;
    logic                   ex_ready;
    logic                   mem_read;
    logic                   mem_write;
    logic [2:0]             funct3;
    logic [REG_WIDTH-1:0]   addr;
    logic [REG_WIDTH-1:0]   store_data;
    logic [4:0]             rd_in;
    // data memory side
    logic                   dmem_req;
    logic                   dmem_we;
    logic [ADDR_WIDTH-1:0]  dmem_addr;
    logic [3:0]             dmem_be;
    logic [31:0]            dmem_wdata;
    logic                   dmem_ack;
    logic [31:0]            dmem_rdata;
    // writeback side
    logic                   wb_valid;
    logic [4:0]             wb_rd;
    logic [31:0]            wb_data;
    logic                   misalign;

    // LSU view
    modport slave (
        input  ex_valid, mem_read, mem_write, funct3, addr, store_data, rd_in,
        input  dmem_ack, dmem_rdata,
        output ex_ready, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output wb_valid, wb_rd, wb_data, misalign
    );

    // environment view (execute stage + memory + writeback)
    modport master (
        output ex_valid, mem_read, mem_write, funct3, addr, store_data, rd_in,
        output dmem_ack, dmem_rdata,
        input  ex_ready, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  wb_valid, wb_rd, wb_data, misalign
    );
endinterface

// File: rtl/lsu.sv
// lsu: load/store unit; single-beat dmem request with byte enables, lane-replicated store data, load extension.
// Latency: dmem_req the cycle after acceptance; wb_valid the cycle after the ack is sampled.
// Backpressure: ex_ready only in IDLE, one transaction outstanding; optional LSU_MISALIGN_TRAP_EN adds a TRAP state.
module lsu #(
    parameter int REG_WIDTH  = 32,
    parameter int ADDR_WIDTH = 32
) (
    input logic  clk,
    input logic  reset_n,
    lsu_if.slave bus
);

`ifdef LSU_MISALIGN_TRAP_EN
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_TRAP} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_REQ} state_t;
`endif

    state_t                 state_q, state_d;
    logic                   we_q, we_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [3:0]             be_q, be_d;
    logic [REG_WIDTH-1:0]   wdata_q, wdata_d;
    logic [2:0]             f3_q, f3_d;
    logic [1:0]             off_q, off_d;
    logic [4:0]             rd_q, rd_d;
    logic                   wb_valid_q, wb_valid_d;
    logic [4:0]             wb_rd_q, wb_rd_d;
    logic [31:0]            wb_data_q, wb_data_d;
    logic                   misalign_q, misalign_d;

    logic [3:0]             be_calc;
    logic [REG_WIDTH-1:0]   wdata_calc;
    logic [7:0]             lane_b;
    logic [15:0]            lane_h;
    logic [31:0]            load_ext;
    logic                   accept;

    assign accept = bus.ex_valid && (bus.mem_read || bus.mem_write);

    // Byte enables and replicated store data from the incoming op; funct3[1:0] picks the size, 1x is word.
    always_comb begin
        be_calc    = 4'b1111;
        wdata_calc = bus.store_data;
        unique case (bus.funct3[1:0])
            2'b00: begin
                be_calc    = 4'b0001 << bus.addr[1:0];
                wdata_calc = {4{bus.store_data[7:0]}};
            end
            2'b01: begin
                be_calc    = 4'b0011 << {bus.addr[1], 1'b0};
                wdata_calc = {2{bus.store_data[15:0]}};
            end
            default: ;
        endcase
    end

`ifdef LSU_MISALIGN_TRAP_EN
    logic mis_calc;
    // Half with odd address, or word not on a 4-byte boundary.
    always_comb begin
        mis_calc = ((bus.funct3[1:0] == 2'b01) && bus.addr[0]) ||
                   (bus.funct3[1] && (bus.addr[1:0] != 2'b00));
    end
`endif

    // Lane selection and sign/zero extension of the returned word using the latched op.
    always_comb begin
        unique case (off_q)
            2'd0:    lane_b = bus.dmem_rdata[7:0];
            2'd1:    lane_b = bus.dmem_rdata[15:8];
            2'd2:    lane_b = bus.dmem_rdata[23:16];
            default: lane_b = bus.dmem_rdata[31:24];
        endcase
        lane_h = off_q[1] ? bus.dmem_rdata[31:16] : bus.dmem_rdata[15:0];
        unique case (f3_q)
            3'b000:  load_ext = {{24{lane_b[7]}}, lane_b};
            3'b001:  load_ext = {{16{lane_h[15]}}, lane_h};
            3'b100:  load_ext = {24'd0, lane_b};
            3'b101:  load_ext = {16'd0, lane_h};
            default: load_ext = bus.dmem_rdata;
        endcase
    end

    // Next-state and next-output computation for the transaction FSM.
    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        addr_d     = addr_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        f3_d       = f3_q;
        off_d      = off_q;
        rd_d       = rd_q;
        wb_valid_d = 1'b0;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;
        misalign_d = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    we_d    = bus.mem_write;
                    addr_d  = {bus.addr[ADDR_WIDTH-1:2], 2'b00};
                    be_d    = be_calc;
                    wdata_d = wdata_calc;
                    f3_d    = bus.funct3;
                    off_d   = bus.addr[1:0];
                    rd_d    = bus.rd_in;
                    state_d = S_REQ;
`ifdef LSU_MISALIGN_TRAP_EN
                    if (mis_calc) begin
                        state_d    = S_TRAP;
                        misalign_d = 1'b1;
                    end
`endif
                end
            end
            S_REQ: begin
                if (bus.dmem_ack) begin
                    state_d = S_IDLE;
                    if (!we_q) begin
                        wb_valid_d = 1'b1;
                        wb_rd_d    = rd_q;
                        wb_data_d  = load_ext;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and registered outputs; reset clears everything immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            we_q       <= 1'b0;
            addr_q     <= '0;
            be_q       <= '0;
            wdata_q    <= '0;
            f3_q       <= '0;
            off_q      <= '0;
            rd_q       <= '0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            f3_q       <= f3_d;
            off_q      <= off_d;
            rd_q       <= rd_d;
            wb_valid_q <= wb_valid_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
            misalign_q <= misalign_d;
        end
    end

    assign bus.ex_ready   = (state_q == S_IDLE);
    assign bus.dmem_req   = (state_q == S_REQ);
    assign bus.dmem_we    = we_q;
    assign bus.dmem_addr  = addr_q;
    assign bus.dmem_be    = be_q;
    assign bus.dmem_wdata = wdata_q;
    assign bus.wb_valid   = wb_valid_q;
    assign bus.wb_rd      = wb_rd_q;
    assign bus.wb_data    = wb_data_q;
    assign bus.misalign   = misalign_q;

endmodule

// File: tb/tb_lsu.sv
// tb_lsu: directed vector table, hand-written corner sequences and random ops against a behavioural model.
// Latency: n/a.
// Backpressure: n/a.
module tb_lsu;
    logic clk;
    logic reset_n;
    int   n_checks;
    int   n_fail;
    logic [31:0] last_wb;
    logic [4:0]  last_rd;

    lsu_if #(.REG_WIDTH(32), .ADDR_WIDTH(32)) bus ();

    lsu #(.REG_WIDTH(32), .ADDR_WIDTH(32)) u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] sd;
        logic [31:0] rdata;
        logic [4:0]  rdi;
        int          waits;
        logic [3:0]  ebe;
        logic [31:0] eaddr;
        logic [31:0] ewdata;
        logic [31:0] eload;
    } vec_t;

    vec_t vt[14];

    task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s.%s: got 0x%08h, expected 0x%08h", nm, fld, act, exp);
        end
    endtask

    function automatic int size_of(input logic [2:0] f3);
        if (f3 == 3'd0 || f3 == 3'd4) return 1;
        if (f3 == 3'd1 || f3 == 3'd5) return 2;
        return 4;
    endfunction

    // Reference behaviour from the access rules: size in bytes, lane offset, mask and extend.
    function automatic void model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] sd,
                                  input logic [31:0] rdata, output logic [3:0] be, output logic [31:0] ea,
                                  output logic [31:0] wd, output logic [31:0] ld);
        int n;
        int off;
        longint unsigned v;
        longint unsigned mask;
        n    = size_of(f3);
        off  = (n == 4) ? 0 : (n == 2) ? ((a % 4) / 2) * 2 : a % 4;
        be   = 4'(((1 << n) - 1) << off);
        wd   = (n == 1) ? sd[7:0] * 32'h01010101 : (n == 2) ? sd[15:0] * 32'h00010001 : sd;
        mask = (64'd1 << (8 * n)) - 64'd1;
        v    = (64'(rdata) >> (8 * off)) & mask;
        if (n < 4 && f3 < 3'd4 && v[8 * n - 1]) v = v | ~mask;
        ld   = v[31:0];
        ea   = a & ~32'd3;
    endfunction

    // One complete op starting and ending at a falling edge with the LSU idle.
    task automatic do_op(input string nm, input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rdata,
                         input logic [4:0] rdi, input int waits, input logic [3:0] ebe,
                         input logic [31:0] eaddr, input logic [31:0] ewdata, input logic [31:0] eload);
        chk(nm, "ex_ready_idle", bus.ex_ready, 1);
        bus.ex_valid   = 1'b1;
        bus.mem_read   = rd;
        bus.mem_write  = wr;
        bus.funct3     = f3;
        bus.addr       = a;
        bus.store_data = sd;
        bus.rd_in      = rdi;
        @(negedge clk);
        bus.ex_valid  = 1'b0;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        chk(nm, "dmem_req", bus.dmem_req, 1);
        chk(nm, "ex_ready_req", bus.ex_ready, 0);
        chk(nm, "dmem_we", bus.dmem_we, wr);
        chk(nm, "dmem_addr", bus.dmem_addr, eaddr);
        chk(nm, "dmem_be", bus.dmem_be, ebe);
        chk(nm, "misalign", bus.misalign, 0);
        if (wr) chk(nm, "dmem_wdata", bus.dmem_wdata, ewdata);
        for (int w = 0; w < waits; w++) begin
            @(negedge clk);
            chk(nm, "dmem_req_wait", bus.dmem_req, 1);
            chk(nm, "dmem_addr_wait", bus.dmem_addr, eaddr);
        end
        bus.dmem_ack   = 1'b1;
        bus.dmem_rdata = rdata;
        @(negedge clk);
        bus.dmem_ack   = 1'b0;
        bus.dmem_rdata = $urandom;
        if (wr) begin
            chk(nm, "wb_valid_store", bus.wb_valid, 0);
        end else begin
            chk(nm, "wb_valid", bus.wb_valid, 1);
            last_wb = eload;
            last_rd = rdi;
        end
        chk(nm, "wb_data", bus.wb_data, last_wb);
        chk(nm, "wb_rd", bus.wb_rd, last_rd);
        chk(nm, "ex_ready_done", bus.ex_ready, 1);
        chk(nm, "dmem_req_done", bus.dmem_req, 0);
        @(negedge clk);
        chk(nm, "wb_valid_pulse", bus.wb_valid, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  mbe;
        logic [31:0] mea, mwd, mld, ra, rsd, rrd;
        logic [2:0]  rf3;
        logic        rrdf, rwr;
        int          n;

        n_checks = 0;
        n_fail   = 0;
        last_wb  = '0;
        last_rd  = '0;
        reset_n        = 1'b0;
        bus.ex_valid   = 1'b0;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.funct3     = '0;
        bus.addr       = '0;
        bus.store_data = '0;
        bus.rd_in      = '0;
        bus.dmem_ack   = 1'b0;
        bus.dmem_rdata = '0;

        //                rd wr f3      addr        sd            rdata         rd  w  be     eaddr       ewdata        eload
        vt[0]  = '{1'b1, 1'b0, 3'b010, 32'h100, 32'h0,        32'hDEADBEEF, 5'd5,  2, 4'hF, 32'h100, 32'h0,        32'hDEADBEEF};
        vt[1]  = '{1'b1, 1'b0, 3'b000, 32'h103, 32'h0,        32'h80123456, 5'd6,  1, 4'h8, 32'h100, 32'h0,        32'hFFFFFF80};
        vt[2]  = '{1'b1, 1'b0, 3'b100, 32'h103, 32'h0,        32'h80123456, 5'd7,  0, 4'h8, 32'h100, 32'h0,        32'h00000080};
        vt[3]  = '{1'b0, 1'b1, 3'b001, 32'h202, 32'h1234ABCD, 32'h0,        5'd8,  1, 4'hC, 32'h200, 32'hABCDABCD, 32'h0};
        vt[4]  = '{1'b1, 1'b0, 3'b001, 32'h102, 32'h0,        32'h80123456, 5'd9,  0, 4'hC, 32'h100, 32'h0,        32'hFFFF8012};
        vt[5]  = '{1'b1, 1'b0, 3'b101, 32'h100, 32'h0,        32'h1234F00D, 5'd10, 2, 4'h3, 32'h100, 32'h0,        32'h0000F00D};
        vt[6]  = '{1'b0, 1'b1, 3'b000, 32'h301, 32'h000000A5, 32'h0,        5'd11, 0, 4'h2, 32'h300, 32'hA5A5A5A5, 32'h0};
        vt[7]  = '{1'b0, 1'b1, 3'b010, 32'h404, 32'hCAFEF00D, 32'h0,        5'd12, 0, 4'hF, 32'h404, 32'hCAFEF00D, 32'h0};
        vt[8]  = '{1'b1, 1'b0, 3'b011, 32'h108, 32'h0,        32'h11223344, 5'd13, 0, 4'hF, 32'h108, 32'h0,        32'h11223344};
        vt[9]  = '{1'b1, 1'b0, 3'b110, 32'h10C, 32'h0,        32'h87654321, 5'd14, 1, 4'hF, 32'h10C, 32'h0,        32'h87654321};
        vt[10] = '{1'b1, 1'b0, 3'b000, 32'h101, 32'h0,        32'h00007F00, 5'd15, 0, 4'h2, 32'h100, 32'h0,        32'h0000007F};
        vt[11] = '{1'b1, 1'b0, 3'b001, 32'h100, 32'h0,        32'h00008000, 5'd16, 0, 4'h3, 32'h100, 32'h0,        32'hFFFF8000};
        vt[12] = '{1'b1, 1'b1, 3'b010, 32'h500, 32'h13579BDF, 32'h0,        5'd17, 0, 4'hF, 32'h500, 32'h13579BDF, 32'h0};
        vt[13] = '{1'b0, 1'b1, 3'b111, 32'h504, 32'h2468ACE0, 32'h0,        5'd18, 0, 4'hF, 32'h504, 32'h2468ACE0, 32'h0};

        // reset state
        repeat (2) @(negedge clk);
        chk("reset", "ex_ready", bus.ex_ready, 1);
        chk("reset", "dmem_req", bus.dmem_req, 0);
        chk("reset", "dmem_we", bus.dmem_we, 0);
        chk("reset", "dmem_addr", bus.dmem_addr, 0);
        chk("reset", "dmem_be", bus.dmem_be, 0);
        chk("reset", "dmem_wdata", bus.dmem_wdata, 0);
        chk("reset", "wb_valid", bus.wb_valid, 0);
        chk("reset", "wb_rd", bus.wb_rd, 0);
        chk("reset", "wb_data", bus.wb_data, 0);
        chk("reset", "misalign", bus.misalign, 0);
        reset_n = 1'b1;
        @(negedge clk);

        // ack while idle is ignored
        bus.dmem_ack   = 1'b1;
        bus.dmem_rdata = 32'hFFFFFFFF;
        @(negedge clk);
        bus.dmem_ack = 1'b0;
        chk("stray_ack", "wb_valid", bus.wb_valid, 0);
        chk("stray_ack", "dmem_req", bus.dmem_req, 0);
        chk("stray_ack", "ex_ready", bus.ex_ready, 1);

        // ex_valid without read or write is ignored
        bus.ex_valid = 1'b1;
        bus.addr     = 32'h700;
        @(negedge clk);
        bus.ex_valid = 1'b0;
        chk("nop", "ex_ready", bus.ex_ready, 1);
        chk("nop", "dmem_req", bus.dmem_req, 0);

        // directed vectors
        for (int i = 0; i < 14; i++) begin
            do_op($sformatf("vec%0d", i), vt[i].rd, vt[i].wr, vt[i].f3, vt[i].a, vt[i].sd, vt[i].rdata,
                  vt[i].rdi, vt[i].waits, vt[i].ebe, vt[i].eaddr, vt[i].ewdata, vt[i].eload);
        end

        // misaligned accesses
`ifdef LSU_MISALIGN_TRAP_EN
        for (int k = 0; k < 2; k++) begin
            chk("mis", "ex_ready_pre", bus.ex_ready, 1);
            bus.ex_valid = 1'b1;
            bus.mem_read = 1'b1;
            bus.funct3   = (k == 0) ? 3'b010 : 3'b001;
            bus.addr     = (k == 0) ? 32'h101 : 32'h103;
            bus.rd_in    = 5'd20;
            @(negedge clk);
            bus.ex_valid = 1'b0;
            bus.mem_read = 1'b0;
            chk("mis", "misalign", bus.misalign, 1);
            chk("mis", "dmem_req", bus.dmem_req, 0);
            chk("mis", "ex_ready_trap", bus.ex_ready, 0);
            chk("mis", "wb_valid", bus.wb_valid, 0);
            @(negedge clk);
            chk("mis", "misalign_once", bus.misalign, 0);
            chk("mis", "ex_ready_back", bus.ex_ready, 1);
            chk("mis", "dmem_req_after", bus.dmem_req, 0);
        end
`else
        do_op("lw_mis", 1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 32'h0BADF00D, 5'd20, 0, 4'hF, 32'h100, 32'h0, 32'h0BADF00D);
        do_op("lh_mis", 1'b1, 1'b0, 3'b001, 32'h103, 32'h0, 32'hC0DE1234, 5'd21, 0, 4'hC, 32'h100, 32'h0, 32'hFFFFC0DE);
`endif

        // random ops against the model
        for (int i = 0; i < 150; i++) begin
            rf3  = 3'($urandom_range(0, 7));
            rrdf = 1'($urandom_range(0, 1));
            rwr  = 1'($urandom_range(0, 1));
            if (!rrdf && !rwr) rrdf = 1'b1;
            ra   = $urandom;
            rsd  = $urandom;
            rrd  = $urandom;
`ifdef LSU_MISALIGN_TRAP_EN
            n  = size_of(rf3);
            ra = ra - (ra % n);
`endif
            model(rf3, ra, rsd, rrd, mbe, mea, mwd, mld);
            do_op($sformatf("rnd%0d", i), rrdf, rwr, rf3, ra, rsd, rrd, 5'($urandom_range(0, 31)),
                  $urandom_range(0, 3), mbe, mea, mwd, mld);
        end

        // back-to-back SW then LW, ex_valid held, zero-wait ack
        chk("b2b", "ex_ready0", bus.ex_ready, 1);
        bus.ex_valid   = 1'b1;
        bus.mem_write  = 1'b1;
        bus.mem_read   = 1'b0;
        bus.funct3     = 3'b010;
        bus.addr       = 32'h600;
        bus.store_data = 32'h55AA55AA;
        bus.dmem_ack   = 1'b1;
        bus.dmem_rdata = 32'h0F0F1234;
        @(negedge clk);
        chk("b2b", "sw_req", bus.dmem_req, 1);
        chk("b2b", "sw_ex_ready", bus.ex_ready, 0);
        chk("b2b", "sw_we", bus.dmem_we, 1);
        chk("b2b", "sw_wdata", bus.dmem_wdata, 32'h55AA55AA);
        bus.mem_write = 1'b0;
        bus.mem_read  = 1'b1;
        bus.addr      = 32'h604;
        bus.rd_in     = 5'd22;
        @(negedge clk);
        chk("b2b", "gap_ex_ready", bus.ex_ready, 1);
        chk("b2b", "gap_req", bus.dmem_req, 0);
        chk("b2b", "gap_wb_valid", bus.wb_valid, 0);
        @(negedge clk);
        chk("b2b", "lw_req", bus.dmem_req, 1);
        chk("b2b", "lw_ex_ready", bus.ex_ready, 0);
        chk("b2b", "lw_we", bus.dmem_we, 0);
        chk("b2b", "lw_addr", bus.dmem_addr, 32'h604);
        bus.ex_valid = 1'b0;
        bus.mem_read = 1'b0;
        @(negedge clk);
        bus.dmem_ack = 1'b0;
        chk("b2b", "wb_valid", bus.wb_valid, 1);
        chk("b2b", "wb_data", bus.wb_data, 32'h0F0F1234);
        chk("b2b", "wb_rd", bus.wb_rd, 22);
        @(negedge clk);

        // asynchronous reset while a load is in REQ
        bus.ex_valid = 1'b1;
        bus.mem_read = 1'b1;
        bus.funct3   = 3'b010;
        bus.addr     = 32'h800;
        bus.rd_in    = 5'd3;
        @(negedge clk);
        bus.ex_valid = 1'b0;
        bus.mem_read = 1'b0;
        chk("rst_req", "dmem_req_before", bus.dmem_req, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_req", "dmem_req_async", bus.dmem_req, 0);
        chk("rst_req", "ex_ready_async", bus.ex_ready, 1);
        @(negedge clk);
        reset_n = 1'b1;
        last_wb = '0;
        last_rd = '0;
        @(negedge clk);
        bus.dmem_ack   = 1'b1;
        bus.dmem_rdata = 32'h12345678;
        @(negedge clk);
        bus.dmem_ack = 1'b0;
        chk("rst_req", "late_ack_wb_valid", bus.wb_valid, 0);
        chk("rst_req", "late_ack_req", bus.dmem_req, 0);
        chk("rst_req", "wb_data", bus.wb_data, last_wb);
        @(negedge clk);
        chk("rst_req", "wb_valid_after", bus.wb_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
